gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
Sequencer that steps a binary index through a programmed range [lo, hi], up or down, one-shot or wrapping. It presents each step's Gray code (g = b ^ (b >> 1)) and its binary index on a valid/ready output stream. It sits in front of Gray-coded consumers such as encoders, pointer logic and test pattern sinks, and owns the bin-to-Gray conversion for them.

Parameters:
WIDTH, 4, bit width of lo, hi, bin and gray.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a run; sampled only in IDLE.
stop  input  1  abort the current run; sampled only in RUN.
dir  input  1  0 = count up (lo to hi), 1 = count down (hi to lo); latched at start.
wrap  input  1  1 = restart at the first value after the last; 0 = one pass; latched at start.
lo  input  WIDTH  range lower bound, inclusive; latched at start.
hi  input  WIDTH  range upper bound, inclusive; latched at start.
out_ready  input  1  consumer accepts the current code.
out_valid  output  1  bin and gray hold a valid step.
bin  output  WIDTH  current binary index (registered).
gray  output  WIDTH  Gray code of bin; combinational from the bin register, never from inputs.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse at the end of a one-shot pass.
err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst_n = 0, asynchronous): state IDLE; bin = 0, so gray = 0; out_valid, busy, done and err all 0; latched configuration cleared. Effect is immediate, including mid-run.
- States: IDLE, RUN, DONE.
- IDLE, start = 1 with lo > hi (unsigned): err = 1 for the next cycle; remain in IDLE; bin unchanged.
- IDLE, start = 1 with lo <= hi:
  - Latch lo, hi, dir and wrap.
  - bin <= (dir ? hi : lo).
  - Go to RUN. out_valid rises in the cycle after start is sampled (latency 1).
- fire = out_valid & out_ready.
- RUN, no fire: bin and gray held stable; out_valid stays 1 (backpressure; no skipped or repeated codes).
- RUN, fire, bin is not the last value: bin <= bin + 1 (up) or bin - 1 (down). Sustained throughput is 1 code per cycle while out_ready = 1.
- The last value is hi when counting up and lo when counting down.
- RUN, fire on the last value:
  - wrap = 1: bin <= first value (lo up, hi down); stay in RUN.
  - wrap = 0: go to DONE; out_valid = 0.
- DONE: done = 1 for exactly one cycle; return to IDLE; bin keeps the last value.
- RUN, stop = 1:
  - Next state IDLE; out_valid = 0; no done pulse.
  - If fire happens in the same cycle, that transfer counts (the consumer keeps the code) and bin does not advance.
  - stop has priority over wrap and over the DONE transition.
- start outside IDLE: ignored. stop outside RUN: ignored. Input changes to lo, hi, dir or wrap during RUN: ignored.
- lo == hi: single code. One-shot emits it once, then done. Wrap emits the same code on every fire.
- Arithmetic is unsigned and modulo 2^WIDTH internally. The range check guarantees that bin never crosses 0 or 2^WIDTH - 1 within a run, so there is no wrap-around overflow.
- busy = 1 exactly in RUN and DONE. out_valid = 1 only in RUN.

Test Plan:
1. Reset, then start with lo = 0, hi = 15, dir = 0, wrap = 0, out_ready = 1:
   - gray stream 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 on 16 consecutive cycles, beginning 1 cycle after start.
   - done pulse 1 cycle after the fire of bin = 15; busy drops the cycle after that.
2. lo = 3, hi = 6, dir = 1, wrap = 1, out_ready = 1:
   - bin 6,5,4,3,6,5,… with gray 5,7,6,2,5,7,…; done never asserts.
   - Assert stop at the second bin = 4: out_valid = 0 next cycle; state IDLE.
3. Backpressure, lo = 0, hi = 3, up, one-shot:
   - out_ready = 1010 0011 11… yields exactly 4 transfers, with gray 0,1,3,2 in order.
   - bin/gray stay stable while out_valid = 1 and out_ready = 0.
4. start with lo = 9, hi = 2 -> err = 1 for one cycle, out_valid stays 0, busy stays 0. A second start issued while busy is ignored.
5. lo = hi = 5, one-shot -> a single transfer with gray = 7, then done. With wrap = 1 -> gray = 7 on every fire.
6. Drive rst_n = 0 asynchronously mid-run (between clock edges) at bin = 9 -> out_valid, busy and bin go to 0 immediately. After release, a new start runs normally from lo.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// Range sequencer: walks a binary index over [lo, hi] up or down, one-shot or wrapping,
// and streams each step's binary index and Gray code over a valid/ready handshake.
module gray_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             dir,
   input  logic             wrap,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             dir_q, dir_d;
   logic             wrap_q, wrap_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             fire_s;
   logic [WIDTH-1:0] first_s;
   logic [WIDTH-1:0] last_s;

   // Next-state, index stepping and status decode
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dir_d   = dir_q;
      wrap_d  = wrap_q;
      err_d   = 1'b0;
      fire_s  = valid_q & out_ready;
      first_s = dir_q ? hi_q : lo_q;
      last_s  = dir_q ? lo_q : hi_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (lo > hi) begin
                  err_d = 1'b1;
               end else begin
                  lo_d    = lo;
                  hi_d    = hi;
                  dir_d   = dir;
                  wrap_d  = wrap;
                  bin_d   = dir ? hi : lo;
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // stop wins over wrap and end-of-pass; a concurrent fire still counts but bin holds
            if (stop) begin
               state_d = ST_IDLE;
            end else if (fire_s) begin
               if (bin_q == last_s) begin
                  if (wrap_q) begin
                     bin_d = first_s;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else if (dir_q) begin
                  bin_d = bin_q - WIDTH'(1);
               end else begin
                  bin_d = bin_q + WIDTH'(1);
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      valid_d = (state_d == ST_RUN);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   // State, index, latched configuration and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         dir_q   <= 1'b0;
         wrap_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         dir_q   <= dir_d;
         wrap_q  <= wrap_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = valid_q;
   assign bin       = bin_q;
   assign gray      = bin2gray(bin_q);
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl: expected {bin,gray} pairs are queued at start,
// and a negedge monitor pops and compares them on every accepted transfer.
module tb_gray_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, dir, wrap, out_ready;
   logic [3:0] lo, hi;
   logic       out_valid, busy, done, err;
   logic [3:0] bin, gray;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   logic [3:0] gray_full [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
   logic       rdy_pat  [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [3:0] bp_bin   [8]  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
   logic [3:0] bp_gray  [8]  = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h3, 4'h2};

   gray_seq_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .wrap(wrap),
      .lo(lo), .hi(hi), .out_ready(out_ready), .out_valid(out_valid), .bin(bin),
      .gray(gray), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] b, input logic [3:0] g);
      exp_q.push_back({b, g});
   endtask

   // Scoreboard monitor: every accepted transfer must match the head of the queue
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_unexpected: got bin=%0h gray=%0h, expected no transfer", bin, gray);
         end else begin
            mon_e = exp_q.pop_front();
            check("xfer", {bin, gray}, mon_e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; wrap = 1'b0;
      lo = 4'd0; hi = 4'd0; out_ready = 1'b0;
      #12;
      check("rst_valid", {7'd0, out_valid}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_bin_gray", {bin, gray}, 8'h00);
      check("rst_done_err", {6'd0, done, err}, 8'd0);
      rst_n = 1'b1;
      tick();

      // 1: full up one-shot sweep
      lo = 4'd0; hi = 4'd15; dir = 1'b0; wrap = 1'b0; out_ready = 1'b1; start = 1'b1;
      for (int i = 0; i < 16; i++) push(4'(i), gray_full[i]);
      tick();
      start = 1'b0;
      check("t1_latency", {7'd0, out_valid}, 8'd1);
      repeat (16) tick();
      check("t1_done", {6'd0, done, busy}, 8'b11);
      check("t1_valid_off", {7'd0, out_valid}, 8'd0);
      tick();
      check("t1_idle", {6'd0, done, busy}, 8'b00);
      check("t1_bin_hold", {4'd0, bin}, 8'd15);
      check("t1_q_empty", 8'(exp_q.size()), 8'd0);

      // 2: down, wrapping, stop on second bin=4
      lo = 4'd3; hi = 4'd6; dir = 1'b1; wrap = 1'b1; start = 1'b1;
      push(4'd6, 4'h5); push(4'd5, 4'h7); push(4'd4, 4'h6); push(4'd3, 4'h2);
      push(4'd6, 4'h5); push(4'd5, 4'h7); push(4'd4, 4'h6);
      tick();
      start = 1'b0;
      check("t2_first", {bin, gray}, {4'd6, 4'h5});
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t2_no_done", {7'd0, done}, 8'd0);
      end
      check("t2_at_stop", {4'd0, bin}, 8'd4);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t2_stop_valid", {6'd0, out_valid, busy}, 8'b00);
      check("t2_stop_bin", {bin, gray}, {4'd4, 4'h6});
      check("t2_stop_done", {7'd0, done}, 8'd0);
      check("t2_q_empty", 8'(exp_q.size()), 8'd0);

      // 3: backpressure, up one-shot 0..3
      lo = 4'd0; hi = 4'd3; dir = 1'b0; wrap = 1'b0; start = 1'b1;
      push(4'd0, 4'h0); push(4'd1, 4'h1); push(4'd2, 4'h3); push(4'd3, 4'h2);
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         out_ready = rdy_pat[i];
         check("t3_hold", {bin, gray}, {bp_bin[i], bp_gray[i]});
         check("t3_valid", {7'd0, out_valid}, 8'd1);
         tick();
      end
      out_ready = 1'b1;
      check("t3_done", {6'd0, done, out_valid}, 8'b10);
      tick();
      check("t3_idle", {7'd0, busy}, 8'd0);
      check("t3_q_empty", 8'(exp_q.size()), 8'd0);

      // 4a: illegal range rejected
      lo = 4'd9; hi = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_err", {5'd0, err, out_valid, busy}, 8'b100);
      check("t4_bin_kept", {4'd0, bin}, 8'd3);
      tick();
      check("t4_err_pulse", {5'd0, err, out_valid, busy}, 8'b000);

      // 4b: start and config changes while busy are ignored
      lo = 4'd1; hi = 4'd2; dir = 1'b0; wrap = 1'b0; start = 1'b1;
      push(4'd1, 4'h1); push(4'd2, 4'h3);
      tick();
      lo = 4'd10; hi = 4'd12; dir = 1'b1; wrap = 1'b1;
      check("t4_run", {bin, 3'd0, busy}, {4'd1, 4'd1});
      tick();
      check("t4_step", {bin, 3'd0, err}, {4'd2, 4'd0});
      tick();
      start = 1'b0;
      check("t4_done", {6'd0, done, err}, 8'b10);
      tick();
      check("t4_idle", {bin, 3'd0, busy}, {4'd2, 4'd0});
      check("t4_q_empty", 8'(exp_q.size()), 8'd0);

      // 5a: lo == hi one-shot
      lo = 4'd5; hi = 4'd5; dir = 1'b0; wrap = 1'b0; start = 1'b1;
      push(4'd5, 4'h7);
      tick();
      start = 1'b0;
      check("t5_single", {bin, gray}, {4'd5, 4'h7});
      tick();
      check("t5_done", {6'd0, done, out_valid}, 8'b10);
      tick();
      check("t5_idle", {7'd0, busy}, 8'd0);

      // 5b: lo == hi wrapping, five fires then stop
      wrap = 1'b1; start = 1'b1;
      for (int i = 0; i < 5; i++) push(4'd5, 4'h7);
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("t5_wrap_stay", {6'd0, busy, out_valid}, 8'b11);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t5_wrap_stop", {5'd0, done, busy, out_valid}, 8'b000);
      check("t5_q_empty", 8'(exp_q.size()), 8'd0);

      // 6: asynchronous reset mid-run at bin = 9
      lo = 4'd0; hi = 4'd15; dir = 1'b0; wrap = 1'b0; start = 1'b1;
      for (int i = 0; i < 9; i++) push(4'(i), gray_full[i]);
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("t6_pre_rst", {bin, gray}, {4'd9, 4'hD});
      #3 rst_n = 1'b0;
      #1;
      check("t6_rst_flags", {6'd0, out_valid, busy}, 8'b00);
      check("t6_rst_bin", {bin, gray}, 8'h00);
      #2 rst_n = 1'b1;
      check("t6_q_empty", 8'(exp_q.size()), 8'd0);
      tick();
      lo = 4'd4; hi = 4'd6; start = 1'b1;
      push(4'd4, 4'h6); push(4'd5, 4'h7); push(4'd6, 4'h5);
      tick();
      start = 1'b0;
      check("t6_restart", {bin, 3'd0, out_valid}, {4'd4, 4'd1});
      repeat (3) tick();
      check("t6_done", {7'd0, done}, 8'd1);
      tick();
      check("t6_idle", {7'd0, busy}, 8'd0);
      check("t6_q_final", 8'(exp_q.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
